alien_field_controller: RTL and testbench

- Upstream producer of the per-slot AlienData array consumed by each quadrant's object layer renderer.
- Owns OBJ_LIMIT alien slots and handles spawn, approach (distance decrement), animation and the kill/explosion sequence.
- Publishes a frame-stable snapshot once per frame tick, so renderers never see a half-updated array.

---
 rtl/alien_field_controller_pkg.sv | 35 +++
 rtl/alien_field_controller_alloc.sv | 31 +++
 rtl/alien_field_controller.sv | 210 +++++++++++++++++++++
 tb/tb_alien_field_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alien_field_controller_pkg.sv
// Shared types and sizing for the alien field controller.
//   AlienData      : per-slot record consumed by the object layer renderers.
//   slot_state_e   : per-slot lifecycle (FREE -> LIVE -> DYING -> FREE).
//   fsm_state_e    : controller sequencing (IDLE -> UPDATE -> PUBLISH).
package alien_field_controller_pkg;

  localparam int unsigned OBJ_LIMIT = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned STEP_DIV  = 8;
  localparam int unsigned ANIM_DIV  = 4;
  localparam int unsigned R_SPAWN   = 15;
  localparam int unsigned STEP_W    = $clog2(STEP_DIV);
  localparam int unsigned ANIM_W    = $clog2(ANIM_DIV);

  typedef struct packed {
    logic [7:0] _deg;
    logic [3:0] _r;
    logic [1:0] _type;
    logic [1:0] _frame_num;
  } AlienData;

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_LIVE,
    SLOT_DYING
  } slot_state_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_PUBLISH
  } fsm_state_e;

endpackage

// File: rtl/alien_field_controller_alloc.sv
// Combinational slot allocator.
//   free_vec : one bit per slot, set when the slot is FREE.
//   free_idx : lowest-index free slot (0 when none is free).
//   any_free : at least one slot is free.
//   free_cnt : number of free slots.
module alien_slot_alloc
  import alien_field_controller_pkg::*;
(
  input  logic [OBJ_LIMIT-1:0] free_vec,
  output logic [IDX_W-1:0]     free_idx,
  output logic                 any_free,
  output logic [CNT_W-1:0]     free_cnt
);

  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    free_cnt = '0;
    for (int unsigned i = 0; i < OBJ_LIMIT; i++) begin
      free_cnt = free_cnt + CNT_W'(free_vec[i]);
    end
    // Scan from the top down so the last hit is the lowest index.
    for (int unsigned i = OBJ_LIMIT; i > 0; i--) begin
      if (free_vec[i-1]) begin
        free_idx = IDX_W'(i - 1);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alien_field_controller.sv
// Alien field controller: owns the alien slots, handles spawn/kill requests
// while idle, walks every slot once per frame tick (approach, animation,
// explosion), then publishes a frame-stable snapshot for the renderers.
//   clk_100MHz, rst_n        : clock, async active-low reset
//   frame_tick               : one-cycle pulse per video frame
//   spawn_valid/type/deg     : spawn request, spawn_ready = accepted
//   kill_valid/idx           : kill request, kill_ready = accepted
//   obj_data, obj_active     : published snapshot and live/dying flags
//   breach                   : pulse when an alien reached _r==0 this frame
//   free_cnt                 : free slots in the working set (registered)
module alien_field_controller
  import alien_field_controller_pkg::*;
(
  input  logic                 clk_100MHz,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic                 spawn_valid,
  input  logic [1:0]           spawn_type,
  input  logic [7:0]           spawn_deg,
  output logic                 spawn_ready,
  input  logic                 kill_valid,
  input  logic [IDX_W-1:0]     kill_idx,
  output logic                 kill_ready,
  output AlienData             obj_data [0:OBJ_LIMIT-1],
  output logic [OBJ_LIMIT-1:0] obj_active,
  output logic                 breach,
  output logic [CNT_W-1:0]     free_cnt
);

  fsm_state_e           state_q, state_d;
  AlienData             work_q [OBJ_LIMIT];
  AlienData             work_d [OBJ_LIMIT];
  slot_state_e          slot_q [OBJ_LIMIT];
  slot_state_e          slot_d [OBJ_LIMIT];
  logic [ANIM_W-1:0]    sub_q  [OBJ_LIMIT];
  logic [ANIM_W-1:0]    sub_d  [OBJ_LIMIT];
  AlienData             pub_q  [OBJ_LIMIT];
  AlienData             pub_d  [OBJ_LIMIT];
  logic [OBJ_LIMIT-1:0] active_q, active_d;
  logic [IDX_W-1:0]     walk_q, walk_d;
  logic [STEP_W-1:0]    step_cnt_q, step_cnt_d;
  logic [ANIM_W-1:0]    anim_cnt_q, anim_cnt_d;
  logic                 step_hit_q, step_hit_d;
  logic                 anim_hit_q, anim_hit_d;
  logic                 breach_pending_q, breach_pending_d;
  logic                 breach_q, breach_d;
  logic [CNT_W-1:0]     free_cnt_q;

  logic [OBJ_LIMIT-1:0] free_vec;
  logic [IDX_W-1:0]     alloc_idx;
  logic                 alloc_any;
  logic [CNT_W-1:0]     alloc_cnt;
  AlienData             cur;

  always_comb begin
    free_vec = '0;
    for (int unsigned i = 0; i < OBJ_LIMIT; i++) begin
      free_vec[i] = (slot_q[i] == SLOT_FREE);
    end
  end

  alien_slot_alloc u_alloc (
    .free_vec (free_vec),
    .free_idx (alloc_idx),
    .any_free (alloc_any),
    .free_cnt (alloc_cnt)
  );

  // State register (all flops).
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      work_q           <= '{default: '0};
      slot_q           <= '{default: SLOT_FREE};
      sub_q            <= '{default: '0};
      pub_q            <= '{default: '0};
      active_q         <= '0;
      walk_q           <= '0;
      step_cnt_q       <= '0;
      anim_cnt_q       <= '0;
      step_hit_q       <= 1'b0;
      anim_hit_q       <= 1'b0;
      breach_pending_q <= 1'b0;
      breach_q         <= 1'b0;
      free_cnt_q       <= CNT_W'(OBJ_LIMIT);
    end else begin
      state_q          <= state_d;
      work_q           <= work_d;
      slot_q           <= slot_d;
      sub_q            <= sub_d;
      pub_q            <= pub_d;
      active_q         <= active_d;
      walk_q           <= walk_d;
      step_cnt_q       <= step_cnt_d;
      anim_cnt_q       <= anim_cnt_d;
      step_hit_q       <= step_hit_d;
      anim_hit_q       <= anim_hit_d;
      breach_pending_q <= breach_pending_d;
      breach_q         <= breach_d;
      free_cnt_q       <= alloc_cnt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (frame_tick) state_d = ST_UPDATE;
      ST_UPDATE:  if (walk_q == IDX_W'(OBJ_LIMIT - 1)) state_d = ST_PUBLISH;
      ST_PUBLISH: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs; the tick cycle itself accepts nothing.
  always_comb begin
    spawn_ready = spawn_valid && (state_q == ST_IDLE) && !frame_tick && alloc_any;
    kill_ready  = kill_valid  && (state_q == ST_IDLE) && !frame_tick;
  end

  // Working-set datapath.
  always_comb begin
    work_d           = work_q;
    slot_d           = slot_q;
    sub_d            = sub_q;
    pub_d            = pub_q;
    active_d         = active_q;
    walk_d           = walk_q;
    step_cnt_d       = step_cnt_q;
    anim_cnt_d       = anim_cnt_q;
    step_hit_d       = step_hit_q;
    anim_hit_d       = anim_hit_q;
    breach_pending_d = breach_pending_q;
    breach_d         = 1'b0;
    cur              = work_q[walk_q];
    unique case (state_q)
      ST_IDLE: begin
        if (spawn_ready) begin
          slot_d[alloc_idx] = SLOT_LIVE;
          work_d[alloc_idx] = '{_deg: spawn_deg, _r: 4'(R_SPAWN),
                                _type: spawn_type, _frame_num: 2'd0};
        end
        if (kill_ready && (slot_q[kill_idx] == SLOT_LIVE)) begin
          slot_d[kill_idx]            = SLOT_DYING;
          work_d[kill_idx]._frame_num = 2'd2;
          sub_d[kill_idx]             = '0;
        end
        // Hit flags are latched on entry so every slot in the walk sees the same decision.
        if (frame_tick) begin
          walk_d     = '0;
          step_hit_d = (step_cnt_q == STEP_W'(STEP_DIV - 1));
          anim_hit_d = (anim_cnt_q == ANIM_W'(ANIM_DIV - 1));
          step_cnt_d = step_hit_d ? '0 : step_cnt_q + 1'b1;
          anim_cnt_d = anim_hit_d ? '0 : anim_cnt_q + 1'b1;
        end
      end
      ST_UPDATE: begin
        walk_d = walk_q + 1'b1;
        unique case (slot_q[walk_q])
          SLOT_LIVE: begin
            if (anim_hit_q) cur._frame_num = {1'b0, ~cur._frame_num[0]};
            if (step_hit_q && (cur._r != '0)) begin
              cur._r = cur._r - 1'b1;
              if (cur._r == '0) begin
                slot_d[walk_q]   = SLOT_FREE;
                breach_pending_d = 1'b1;
              end
            end
            work_d[walk_q] = cur;
          end
          // Explosion frames run off a per-slot counter that restarts at the kill.
          SLOT_DYING: begin
            if (sub_q[walk_q] == ANIM_W'(ANIM_DIV - 1)) begin
              sub_d[walk_q] = '0;
              if (cur._frame_num == 2'd2) begin
                cur._frame_num = 2'd3;
              end else begin
                cur            = '0;
                slot_d[walk_q] = SLOT_FREE;
              end
              work_d[walk_q] = cur;
            end else begin
              sub_d[walk_q] = sub_q[walk_q] + 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_PUBLISH: begin
        pub_d = work_q;
        for (int unsigned i = 0; i < OBJ_LIMIT; i++) begin
          active_d[i] = (slot_q[i] != SLOT_FREE);
        end
        breach_d         = breach_pending_q;
        breach_pending_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign obj_data   = pub_q;
  assign obj_active = active_q;
  assign breach     = breach_q;
  assign free_cnt   = free_cnt_q;

  // Ticks are spaced far beyond one walk; one arriving mid-walk is dropped.
  ap_tick_in_idle: assert property (@(posedge clk_100MHz) disable iff (!rst_n)
    frame_tick |-> (state_q == ST_IDLE));

endmodule

// File: tb/tb_alien_field_controller.sv
module tb_alien_field_controller;
  import alien_field_controller_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 frame_tick = 1'b0;
  logic                 spawn_valid = 1'b0;
  logic [1:0]           spawn_type = '0;
  logic [7:0]           spawn_deg = '0;
  logic                 spawn_ready;
  logic                 kill_valid = 1'b0;
  logic [IDX_W-1:0]     kill_idx = '0;
  logic                 kill_ready;
  AlienData             obj_data [0:OBJ_LIMIT-1];
  logic [OBJ_LIMIT-1:0] obj_active;
  logic                 breach;
  logic [CNT_W-1:0]     free_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] active;
    bit          chk_fields;
    int unsigned slot;
    logic [7:0]  deg;
    logic [3:0]  r;
    logic [1:0]  typ;
    logic [1:0]  frm;
    logic        brch;
  } exp_t;

  exp_t sb[$];

  alien_field_controller dut (
    .clk_100MHz  (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .spawn_valid (spawn_valid),
    .spawn_type  (spawn_type),
    .spawn_deg   (spawn_deg),
    .spawn_ready (spawn_ready),
    .kill_valid  (kill_valid),
    .kill_idx    (kill_idx),
    .kill_ready  (kill_ready),
    .obj_data    (obj_data),
    .obj_active  (obj_active),
    .breach      (breach),
    .free_cnt    (free_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] act, input bit chk, input int unsigned slot,
                              input logic [7:0] deg, input logic [3:0] r, input logic [1:0] typ,
                              input logic [1:0] frm, input logic brch);
    exp_t e;
    e.active = act; e.chk_fields = chk; e.slot = slot; e.deg = deg;
    e.r = r; e.typ = typ; e.frm = frm; e.brch = brch;
    return e;
  endfunction

  // Monitor: the snapshot and breach pulse appear 17 edges after the edge that samples the tick.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (frame_tick === 1'b1) begin
        repeat (17) @(posedge clk);
        #1;
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("obj_active", 32'(obj_active), 32'(e.active));
          check("breach", 32'(breach), 32'(e.brch));
          if (e.chk_fields) begin
            check("slot_deg", 32'(obj_data[e.slot]._deg), 32'(e.deg));
            check("slot_r", 32'(obj_data[e.slot]._r), 32'(e.r));
            check("slot_type", 32'(obj_data[e.slot]._type), 32'(e.typ));
            check("slot_frame", 32'(obj_data[e.slot]._frame_num), 32'(e.frm));
          end
        end
      end
    end
  end

  task automatic tick(input exp_t e);
    @(negedge clk);
    sb.push_back(e);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic spawn(input logic [1:0] typ, input logic [7:0] deg, input logic exp_rdy);
    @(negedge clk);
    spawn_valid = 1'b1; spawn_type = typ; spawn_deg = deg;
    #1 check("spawn_ready", 32'(spawn_ready), 32'(exp_rdy));
    @(negedge clk);
    spawn_valid = 1'b0;
  endtask

  task automatic kill(input logic [IDX_W-1:0] idx);
    @(negedge clk);
    kill_valid = 1'b1; kill_idx = idx;
    #1 check("kill_ready", 32'(kill_ready), 32'd1);
    @(negedge clk);
    kill_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, held in reset.
    repeat (2) @(negedge clk);
    check("rst_obj_active", 32'(obj_active), 32'd0);
    check("rst_free_cnt", 32'(free_cnt), 32'd16);
    check("rst_breach", 32'(breach), 32'd0);
    check("rst_spawn_ready", 32'(spawn_ready), 32'd0);
    check("rst_kill_ready", 32'(kill_ready), 32'd0);
    check("rst_obj_data0", 32'(obj_data[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty field: three ticks publish nothing.
    for (int i = 0; i < 3; i++) tick(mk(16'h0, 1'b1, 0, 8'h0, 4'h0, 2'd0, 2'd0, 1'b0));
    check("empty_free_cnt", 32'(free_cnt), 32'd16);

    // Single spawn lands in slot 0.
    do_reset();
    spawn(2'd2, 8'h40, 1'b1);
    @(negedge clk);
    check("spawn_free_cnt", 32'(free_cnt), 32'd15);
    tick(mk(16'h0001, 1'b1, 0, 8'h40, 4'd15, 2'd2, 2'd0, 1'b0));

    // Approach: _r drops every 8th tick, frame toggles every 4th, breach on tick 120.
    do_reset();
    spawn(2'd1, 8'h11, 1'b1);
    for (int k = 1; k <= 120; k++) begin
      if (k < 120)
        tick(mk(16'h0001, 1'b1, 0, 8'h11, 4'(15 - k / 8), 2'd1, 2'((k / 4) % 2), 1'b0));
      else
        tick(mk(16'h0000, 1'b0, 0, 8'h0, 4'h0, 2'd0, 2'd0, 1'b1));
    end
    check("breach_free_cnt", 32'(free_cnt), 32'd16);

    // Kill: frame 2 after the kill, 3 on the 4th tick after it, freed on the 8th.
    do_reset();
    spawn(2'd3, 8'h22, 1'b1);
    tick(mk(16'h0001, 1'b1, 0, 8'h22, 4'd15, 2'd3, 2'd0, 1'b0));
    kill(4'd0);
    kill(4'd9);  // free slot: accepted, no effect
    for (int j = 1; j <= 8; j++) begin
      if (j < 8)
        tick(mk(16'h0001, 1'b1, 0, 8'h22, 4'd15, 2'd3, (j < 4) ? 2'd2 : 2'd3, 1'b0));
      else
        tick(mk(16'h0000, 1'b1, 0, 8'h0, 4'h0, 2'd0, 2'd0, 1'b0));
    end

    // Full field, 17th spawn refused until slot 5 finishes exploding.
    do_reset();
    for (int i = 0; i < 16; i++) spawn(2'(i % 4), 8'(i * 16), 1'b1);
    @(negedge clk);
    check("full_free_cnt", 32'(free_cnt), 32'd0);
    spawn(2'd3, 8'hAA, 1'b0);
    kill(4'd5);
    for (int j = 1; j <= 8; j++) begin
      if (j < 8)
        tick(mk(16'hFFFF, 1'b1, 5, 8'h50, 4'd15, 2'd1, (j < 4) ? 2'd2 : 2'd3, 1'b0));
      else
        tick(mk(16'hFFDF, 1'b1, 5, 8'h0, 4'h0, 2'd0, 2'd0, 1'b0));
    end
    check("one_free_cnt", 32'(free_cnt), 32'd1);
    spawn(2'd3, 8'hAA, 1'b1);
    @(negedge clk);
    check("refill_free_cnt", 32'(free_cnt), 32'd0);
    tick(mk(16'hFFFF, 1'b1, 5, 8'hAA, 4'd15, 2'd3, 2'd0, 1'b0));

    // Reset mid-walk at slot 7: immediate clear, no publish afterwards.
    do_reset();
    spawn(2'd0, 8'h33, 1'b1);
    tick(mk(16'h0001, 1'b1, 0, 8'h33, 4'd15, 2'd0, 2'd0, 1'b0));
    spawn(2'd1, 8'h44, 1'b1);
    @(negedge clk);
    sb.push_back(mk(16'h0000, 1'b1, 0, 8'h0, 4'h0, 2'd0, 2'd0, 1'b0));
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_obj_active", 32'(obj_active), 32'd0);
    check("midrst_obj_data0", 32'(obj_data[0]), 32'd0);
    check("midrst_free_cnt", 32'(free_cnt), 32'd16);
    check("midrst_breach", 32'(breach), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    spawn(2'd2, 8'h55, 1'b1);
    tick(mk(16'h0001, 1'b1, 0, 8'h55, 4'd15, 2'd2, 2'd0, 1'b0));

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
